// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: state encoding and CPSR-style flag bit positions shared by the subtractor
package serial_subtractor_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: gate-level one-bit a - b - borrow_in cell
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);
  assign diff       = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~a & borrow_in) | (b & borrow_in);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first A - B with N/Z/C/V flags
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);
  localparam int CNT_W = $clog2(WIDTH);
  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr, b_sr, res;
  logic [CNT_W-1:0] count;
  logic [3:0]       flags;
  logic             borrow, zacc, a_msb, b_msb, d, bout, last;
  full_subtractor u_fs (
    .a         (a_sr[0]),
    .b         (b_sr[0]),
    .borrow_in (borrow),
    .diff      (d),
    .borrow_out(bout)
  );
  assign last       = count == CNT_W'(WIDTH - 1);
  assign ready      = state == S_IDLE;
  assign busy       = state == S_RUN;
  assign done       = state == S_DONE;
  assign difference = res;
  assign flag_n     = flags[FLAG_N];
  assign flag_z     = flags[FLAG_Z];
  assign flag_c     = flags[FLAG_C];
  assign flag_v     = flags[FLAG_V];
  // Operand capture, one subtractor bit per RUN cycle, flag latch on the final bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      count  <= '0;
      flags  <= '0;
      borrow <= 1'b0;
      zacc   <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
    end else if (state == S_IDLE && start) begin
      a_sr   <= minuend;
      b_sr   <= subtrahend;
      a_msb  <= minuend[WIDTH-1];
      b_msb  <= subtrahend[WIDTH-1];
      borrow <= 1'b0;
      count  <= '0;
      zacc   <= 1'b1;
      state  <= S_RUN;
    end else if (state == S_RUN) begin
      res    <= {d, res[WIDTH-1:1]};
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      borrow <= bout;
      zacc   <= zacc & ~d;
      count  <= count + CNT_W'(1);
      if (last) begin
        flags[FLAG_N] <= d;
        flags[FLAG_Z] <= zacc & ~d;
        flags[FLAG_C] <= ~bout;
        flags[FLAG_V] <= (a_msb != b_msb) && (d != a_msb);
        state         <= S_DONE;
      end
    end else if (state == S_DONE) begin
      state <= S_IDLE;
    end
  end
endmodule
